// File: rtl/tile_map_render_pkg.sv
// Shared constants, FSM encoding and the Galois LFSR step for the tile-map
// background renderer.
package tile_map_render_pkg;

   localparam int VGA_CNT_W = 11;
   localparam int RGB_W     = 12;

   localparam logic [RGB_W-1:0] DEF_COLOR_SQUARE = 12'h0FF;
   localparam logic [RGB_W-1:0] DEF_COLOR_GRID   = 12'h333;
   localparam logic [RGB_W-1:0] DEF_COLOR_BG     = 12'h000;
   localparam logic [RGB_W-1:0] COLOR_BLANK      = 12'h000;

   localparam logic [15:0] LFSR_TAPS        = 16'hB400;
   localparam logic [15:0] DEF_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VB = 2'd1,
      FILL    = 2'd2,
      DONE    = 2'd3
   } fsm_t;

   // Right-shifting Galois step: the bit shifted out folds the taps back in.
   function automatic logic [15:0] galois_step(input logic [15:0] q);
      logic [15:0] nxt;
      nxt = {1'b0, q[15:1]};
      if (q[0]) begin
         nxt = nxt ^ LFSR_TAPS;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and pixel bundle passed between background-chain stages.
interface vga_if;
   import tile_map_render_pkg::*;

   logic [VGA_CNT_W-1:0] vcount;
   logic                 vsync;
   logic                 vblnk;
   logic [VGA_CNT_W-1:0] hcount;
   logic                 hsync;
   logic                 hblnk;
   logic [RGB_W-1:0]     rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/tile_map_render_lfsr16.sv
// 16-bit Galois LFSR with synchronous load; reusable by other random features.
module lfsr16
   import tile_map_render_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = DEF_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        en,
   output logic [15:0] q
);

   // Load wins over advance so a fresh seed is never skipped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= seed;
      end else if (en) begin
         q <= galois_step(q);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/tile_map_render.sv
// Tile-map background renderer: LFSR-filled occupancy map drawn into the
// vga_if stream with a fixed two-cycle latency.
module tile_map_render
   import tile_map_render_pkg::*;
#(
   parameter int               CELL_LOG2    = 5,
   parameter int               CELLS_X      = 32,
   parameter int               CELLS_Y      = 24,
   parameter int               BORDER       = 1,
   parameter logic [RGB_W-1:0] COLOR_SQUARE = DEF_COLOR_SQUARE,
   parameter logic [RGB_W-1:0] COLOR_GRID   = DEF_COLOR_GRID,
   parameter logic [RGB_W-1:0] COLOR_BG     = DEF_COLOR_BG,
   parameter logic [15:0]      DEFAULT_SEED = DEF_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   vga_if.in           bg_in,
   vga_if.out          bg_out,
   input  logic        regen,
   input  logic [15:0] seed,
   input  logic [7:0]  density,
   output logic        busy,
   output logic        done
);

   localparam int MAP_N  = CELLS_X * CELLS_Y;
   localparam int IDX_W  = $clog2(MAP_N);
   localparam int CELL_W = VGA_CNT_W - CELL_LOG2;

   localparam logic [CELL_LOG2-1:0] BORDER_V = CELL_LOG2'(BORDER);
   localparam logic [CELL_W:0]      CELLS_XV = (CELL_W + 1)'(CELLS_X);
   localparam logic [CELL_W:0]      CELLS_YV = (CELL_W + 1)'(CELLS_Y);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(MAP_N - 1);

   // ---------------------------------------------------------------- render
   logic [VGA_CNT_W-1:0] s1_vcount, s1_hcount;
   logic                 s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
   logic [CELL_W-1:0]    s1_cx, s1_cy;
   logic [CELL_LOG2-1:0] s1_ox, s1_oy;
   logic                 s1_on_map;

   logic [CELL_W-1:0]    cx_s, cy_s;
   logic                 on_map_s;
   logic [IDX_W-1:0]     rd_idx_s;
   logic                 cell_s;
   logic [RGB_W-1:0]     rgb_s;
   logic [MAP_N-1:0]     map_r;

   assign cx_s     = bg_in.hcount[VGA_CNT_W-1:CELL_LOG2];
   assign cy_s     = bg_in.vcount[VGA_CNT_W-1:CELL_LOG2];
   assign on_map_s = ({1'b0, cx_s} < CELLS_XV) && ({1'b0, cy_s} < CELLS_YV);

   // Stage 1: register timing and split pixel position into cell + offset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vcount <= {VGA_CNT_W{1'b0}};
         s1_hcount <= {VGA_CNT_W{1'b0}};
         s1_vsync  <= 1'b0;
         s1_vblnk  <= 1'b0;
         s1_hsync  <= 1'b0;
         s1_hblnk  <= 1'b0;
         s1_cx     <= {CELL_W{1'b0}};
         s1_cy     <= {CELL_W{1'b0}};
         s1_ox     <= {CELL_LOG2{1'b0}};
         s1_oy     <= {CELL_LOG2{1'b0}};
         s1_on_map <= 1'b0;
      end else begin
         s1_vcount <= bg_in.vcount;
         s1_hcount <= bg_in.hcount;
         s1_vsync  <= bg_in.vsync;
         s1_vblnk  <= bg_in.vblnk;
         s1_hsync  <= bg_in.hsync;
         s1_hblnk  <= bg_in.hblnk;
         s1_cx     <= cx_s;
         s1_cy     <= cy_s;
         s1_ox     <= bg_in.hcount[CELL_LOG2-1:0];
         s1_oy     <= bg_in.vcount[CELL_LOG2-1:0];
         s1_on_map <= on_map_s;
      end
   end

   // Index may alias when off the map; on_map masks those reads.
   assign rd_idx_s = IDX_W'(s1_cy) * IDX_W'(CELLS_X) + IDX_W'(s1_cx);
   assign cell_s   = s1_on_map ? map_r[rd_idx_s] : 1'b0;

   // Stage 2 colour priority: blank, off-map, grid line, occupied, empty.
   always_comb begin
      rgb_s = COLOR_BG;
      if (s1_vblnk || s1_hblnk) begin
         rgb_s = COLOR_BLANK;
      end else if (!s1_on_map) begin
         rgb_s = COLOR_BG;
      end else if ((BORDER > 0) && ((s1_ox < BORDER_V) || (s1_oy < BORDER_V))) begin
         rgb_s = COLOR_GRID;
      end else if (cell_s) begin
         rgb_s = COLOR_SQUARE;
      end else begin
         rgb_s = COLOR_BG;
      end
   end

   // Stage 2: output register for the whole stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bg_out.vcount <= {VGA_CNT_W{1'b0}};
         bg_out.hcount <= {VGA_CNT_W{1'b0}};
         bg_out.vsync  <= 1'b0;
         bg_out.vblnk  <= 1'b0;
         bg_out.hsync  <= 1'b0;
         bg_out.hblnk  <= 1'b0;
         bg_out.rgb    <= COLOR_BG;
      end else begin
         bg_out.vcount <= s1_vcount;
         bg_out.hcount <= s1_hcount;
         bg_out.vsync  <= s1_vsync;
         bg_out.vblnk  <= s1_vblnk;
         bg_out.hsync  <= s1_hsync;
         bg_out.hblnk  <= s1_hblnk;
         bg_out.rgb    <= rgb_s;
      end
   end

   // ------------------------------------------------------------------ fill
   fsm_t             state_r;
   logic [IDX_W-1:0] idx_r;
   logic [7:0]       dens_r;
   logic             vblnk_prev_r;
   logic             busy_r, done_r;
   logic [15:0]      lfsr_q_s, seed_eff_s;
   logic             load_s, en_s, vb_rise_s, occ_s;

   assign seed_eff_s = (seed == 16'h0000) ? DEFAULT_SEED : seed;
   assign load_s     = (state_r == IDLE) && regen;
   assign en_s       = (state_r == FILL);
   assign vb_rise_s  = bg_in.vblnk && !vblnk_prev_r;
   assign occ_s      = (dens_r == 8'hFF) ? 1'b1 : (lfsr_q_s[7:0] < dens_r);

   lfsr16 #(
      .RESET_VAL (DEFAULT_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .seed  (seed_eff_s),
      .en    (en_s),
      .q     (lfsr_q_s)
   );

   // Previous vblnk, tracked in every state so entry to WAIT_VB mid-blank
   // does not count as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_prev_r <= 1'b0;
      end else begin
         vblnk_prev_r <= bg_in.vblnk;
      end
   end

   // Fill sequencer: request, wait for blanking, one cell per cycle, report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= {IDX_W{1'b0}};
         dens_r  <= 8'h00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (regen) begin
                  dens_r  <= density;
                  busy_r  <= 1'b1;
                  state_r <= WAIT_VB;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT_VB: begin
               if (vb_rise_s) begin
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= FILL;
               end else begin
                  state_r <= WAIT_VB;
               end
            end
            FILL: begin
               if (idx_r == LAST_IDX) begin
                  idx_r   <= {IDX_W{1'b0}};
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  state_r <= FILL;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Occupancy map: cleared by reset, written one cell per FILL cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_r <= {MAP_N{1'b0}};
      end else if (state_r == FILL) begin
         map_r[idx_r] <= occ_s;
      end else begin
         map_r <= map_r;
      end
   end

   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_tile_map_render.sv
// Scoreboard bench for tile_map_render: expected pixels are queued as they
// are driven and compared as the DUT emits them two clocks later.
module tb_tile_map_render;
   import tile_map_render_pkg::*;

   typedef struct packed {
      logic        chk;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        regen = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [7:0]  density = 8'h00;
   logic        busy, done;

   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   bit   model_map [768];
   exp_t sb [$];

   vga_if vin ();
   vga_if vout ();

   tile_map_render dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bg_in   (vin),
      .bg_out  (vout),
      .regen   (regen),
      .seed    (seed),
      .density (density),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
   endfunction

   function automatic int build_model(input logic [15:0] s_in, input logic [7:0] d);
      logic [15:0] s;
      int          cnt;
      s   = (s_in == 16'h0000) ? 16'hACE1 : s_in;
      cnt = 0;
      for (int i = 0; i < 768; i++) begin
         model_map[i] = (d == 8'hFF) ? 1'b1 : (s[7:0] < d);
         if (model_map[i]) cnt++;
         s = lfsr_next(s);
      end
      return cnt;
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < 768; i++) model_map[i] = 1'b0;
   endfunction

   function automatic logic [11:0] exp_rgb(input logic [10:0] h, v, input logic hb, vb);
      int cx, cy;
      cx = int'(h) / 32;
      cy = int'(v) / 32;
      if (hb || vb) return 12'h000;
      if (cx >= 32 || cy >= 24) return 12'h000;
      if (h[4:0] == 5'd0 || v[4:0] == 5'd0) return 12'h333;
      return model_map[cy * 32 + cx] ? 12'h0FF : 12'h000;
   endfunction

   function automatic logic [37:0] obs_vec();
      return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
   endfunction

   function automatic logic [37:0] exp_vec(input exp_t o);
      return {o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.rgb};
   endfunction

   // Drive one pixel, queue its expectation, advance a clock, hand back the
   // expectation now due at the output (if any).
   task automatic step(input logic [10:0] h, v, input logic hb, vb, input logic chk,
                       output logic got, output exp_t o);
      exp_t e;
      vin.hcount = h;
      vin.vcount = v;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.hsync  = h[0];
      vin.vsync  = v[1];
      vin.rgb    = 12'hABC;
      e = '{chk: chk, h: h, v: v, hs: h[0], vs: v[1], hb: hb, vb: vb,
            rgb: exp_rgb(h, v, hb, vb)};
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = 1'b0;
      o   = '0;
      if (sb.size() >= 2) begin
         o   = sb.pop_front();
         got = 1'b1;
      end
   endtask

   task automatic do_regen(input logic [15:0] s, input logic [7:0] d);
      logic got;
      exp_t o;
      seed    = s;
      density = d;
      regen   = 1'b1;
      step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, got, o);
      regen = 1'b0;
      step(11'd0, 11'd0, 1'b1, 1'b0, 1'b0, got, o);
   endtask

   // Holds vblnk high (the first step is the rising edge) and counts clocks
   // until done; optionally re-pulses regen at clock pulse_at.
   task automatic wait_done(input int pulse_at, output int n);
      logic got;
      exp_t o;
      n = -1;
      for (int k = 1; k <= 3000; k++) begin
         if (k == pulse_at) begin
            regen   = 1'b1;
            seed    = 16'h1111;
            density = 8'hFF;
         end
         step(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, got, o);
         regen = 1'b0;
         if (done === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic dump_map(output int mism, output int occ);
      logic got;
      exp_t o;
      mism = 0;
      occ  = 0;
      for (int i = 0; i <= 768; i++) begin
         if (i < 768)
            step(11'((i % 32) * 32 + 16), 11'((i / 32) * 32 + 16), 1'b0, 1'b0, 1'b1, got, o);
         else
            step(11'd0, 11'd0, 1'b1, 1'b1, 1'b0, got, o);
         if (got && o.chk) begin
            if (obs_vec() !== exp_vec(o)) mism++;
            if (vout.rgb === 12'h0FF) occ++;
         end
      end
   endtask

   task automatic test_reset();
      logic got;
      exp_t o;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== 38'h0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: out=%h busy=%b done=%b, want all 0", obs_vec(), busy, done);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(11'd100, 11'd100, 1'b0, 1'b0, 1'b1, got, o);
         if (got && o.chk) begin
            checks++;
            if (obs_vec() !== exp_vec(o)) begin
               failures++;
               $display("FAIL reset_run: got %h want %h", obs_vec(), exp_vec(o));
            end
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== 38'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: out=%h busy=%b, want 0", obs_vec(), busy);
      end
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_latency();
      logic [10:0] hs [7] = '{11'd40, 11'd32, 11'd40, 11'd40, 11'd1030, 11'd40, 11'd0};
      logic [10:0] vs [7] = '{11'd40, 11'd40, 11'd32, 11'd40, 11'd40, 11'd770, 11'd0};
      logic        hb [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        got;
      exp_t        o;
      for (int i = 0; i < 7; i++) begin
         step(hs[i], vs[i], hb[i], 1'b0, (i < 6), got, o);
         if (got && o.chk) begin
            checks++;
            if (obs_vec() !== exp_vec(o)) begin
               failures++;
               $display("FAIL latency_px%0d: got %h want %h", i, obs_vec(), exp_vec(o));
            end
         end
      end
   endtask

   task automatic test_full_map();
      int          n, d0;
      logic        got;
      exp_t        o;
      logic [10:0] h, v;
      do_regen(16'h0000, 8'hFF);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL full_busy: busy=%b want 1", busy);
      end
      d0 = done_cnt;
      wait_done(-1, n);
      checks++;
      if (n != 769) begin
         failures++;
         $display("FAIL full_done_cycle: done after %0d clocks, want 769", n);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL full_busy_clear: busy=%b want 0", busy);
      end
      void'(build_model(16'h0000, 8'hFF));
      for (int i = 0; i <= 44; i++) begin
         case (i)
            0: begin h = 11'd1024; v = 11'd100; end
            1: begin h = 11'd100;  v = 11'd768; end
            2: begin h = 11'd2000; v = 11'd50;  end
            3: begin h = 11'd64;   v = 11'd77;  end
            default: begin h = 11'($urandom_range(1100, 0)); v = 11'($urandom_range(800, 0)); end
         endcase
         step(h, v, 1'b0, 1'b0, (i < 44), got, o);
         if (got && o.chk) begin
            checks++;
            if (obs_vec() !== exp_vec(o)) begin
               failures++;
               $display("FAIL full_px h=%0d v=%0d: got %h want %h", o.h, o.v, obs_vec(), exp_vec(o));
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL full_done_pulses: %0d pulses, want 1", done_cnt - d0);
      end
   endtask

   task automatic test_determinism();
      int n, mism, occ, want;
      for (int r = 0; r < 2; r++) begin
         do_regen(16'h1234, 8'h80);
         wait_done(-1, n);
         checks++;
         if (n != 769) begin
            failures++;
            $display("FAIL det_done_%0d: done after %0d clocks, want 769", r, n);
         end
         want = build_model(16'h1234, 8'h80);
         dump_map(mism, occ);
         checks++;
         if (mism != 0) begin
            failures++;
            $display("FAIL det_map_%0d: %0d cells differ, want 0", r, mism);
         end
         checks++;
         if (occ != want) begin
            failures++;
            $display("FAIL det_count_%0d: occupied %0d want %0d", r, occ, want);
         end
      end
   endtask

   task automatic test_regen_busy();
      int   n, d0, mism, occ, want;
      logic got;
      exp_t o;
      d0 = done_cnt;
      do_regen(16'h5A5A, 8'h40);
      wait_done(100, n);
      checks++;
      if (n != 769) begin
         failures++;
         $display("FAIL busy_done_cycle: done after %0d clocks, want 769", n);
      end
      repeat (20) step(11'd0, 11'd0, 1'b1, 1'b1, 1'b0, got, o);
      checks++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_single_done: pulses=%0d busy=%b, want 1 and 0", done_cnt - d0, busy);
      end
      want = build_model(16'h5A5A, 8'h40);
      dump_map(mism, occ);
      checks++;
      if (mism != 0 || occ != want) begin
         failures++;
         $display("FAIL busy_map: mism=%0d occ=%0d, want 0 and %0d", mism, occ, want);
      end
   endtask

   task automatic test_reset_mid_fill();
      int   d0, mism, occ;
      logic got;
      exp_t o;
      do_regen(16'h1234, 8'hFF);
      repeat (301) step(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, got, o);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL midfill_busy: busy=%b want 1", busy);
      end
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || obs_vec() !== 38'h0) begin
         failures++;
         $display("FAIL midfill_reset: busy=%b out=%h, want 0", busy, obs_vec());
      end
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      repeat (1000) step(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, got, o);
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midfill_no_done: pulses=%0d busy=%b, want 0", done_cnt - d0, busy);
      end
      clear_model();
      dump_map(mism, occ);
      checks++;
      if (mism != 0 || occ != 0) begin
         failures++;
         $display("FAIL midfill_map: mism=%0d occ=%0d, want 0 and 0", mism, occ);
      end
   endtask

   initial begin
      vin.hcount = 11'd0;
      vin.vcount = 11'd0;
      vin.hsync  = 1'b0;
      vin.vsync  = 1'b0;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.rgb    = 12'h000;
      clear_model();
      test_reset();
      test_latency();
      test_full_map();
      test_determinism();
      test_regen_busy();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
